spi_sd_responder: RTL
=====================

Name: spi_sd_responder

Overview:
- SPI mode-0 target that models the card side of the SD SPI link, so the SD host path can be exercised in loopback and simulation.
- Oversamples host SCLK/MOSI/CS_N in the system clock domain and frames 6-byte SD commands (start bits 01, 6-bit index, 32-bit argument, CRC7 + end bit).
- Hands each command to user logic over a valid/ready handshake, then returns the user-supplied R1 byte on MISO after NCR filler bytes.

Parameters:
- NCR_BYTES, 1, number of 0xFF filler bytes sent between command end and R1; legal range 1..8.
- SYNC_STAGES, 2, synchronizer depth for sclk/mosi/cs_n; legal range >=2.

Ports:
- clk  in  1  system clock; must be >= 8x SCLK frequency.
- rst_n  in  1  asynchronous, active-low reset.
- sd_clk  in  1  host SPI clock (asynchronous).
- sd_mosi  in  1  host-to-card data.
- sd_cs_n  in  1  host chip select, active low.
- sd_miso  out  1  card-to-host data.
- sd_miso_oe  out  1  MISO drive enable; high only while CS is low.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  user accepts command.
- cmd_index  out  6  command index (byte0[5:0]).
- cmd_arg  out  32  argument, big-endian (bytes 1..4).
- cmd_crc  out  7  received CRC7 (byte5[7:1]).
- rsp_valid  in  1  user R1 byte valid.
- rsp_data  in  8  R1 byte.
- rsp_ready  out  1  responder accepts R1.

Behaviour:
- Reset values (rst_n low): sd_miso=1, sd_miso_oe=0, cmd_valid=0, rsp_ready=0, cmd_index/cmd_arg/cmd_crc=0, state=IDLE, bit counter=0.
- Input synchronization: sd_clk, sd_mosi and sd_cs_n each pass through SYNC_STAGES flops. Edge detect is done on the synchronized sd_clk.
- Sampling and shifting:
  - Synchronized SCLK rising edge: shift synchronized MOSI into the RX shift register, MSB first.
  - SCLK falling edge: shift the TX register out on sd_miso.
- Byte boundaries:
  - A 3-bit bit counter wraps every 8 rising edges; the 8th rising edge is the byte boundary.
  - At each boundary, the next TX byte is loaded so its MSB is on sd_miso before the following rising edge.
  - Synchronized CS_N falling edge clears the bit counter and preloads TX with 0xFF.
- CS high (synchronized): sd_miso_oe=0, sd_miso=1. Any state aborts to IDLE, cmd_valid and rsp_ready drop, and a held response is discarded.
- States:
  - IDLE: TX=0xFF. A received byte with bits[7:6]==01 latches index and goes to CMD; any other byte (e.g. 0xFF) is ignored.
  - CMD: collects bytes 1..5; byte5 bit0 is not checked. After byte5 -> WAIT_CMD with cmd_valid=1 on the next clk. cmd_* outputs stay stable while cmd_valid is high.
  - WAIT_CMD: on cmd_valid&&cmd_ready -> cmd_valid=0, go to WAIT_RSP with rsp_ready=1.
  - WAIT_RSP: on rsp_valid&&rsp_ready -> hold rsp_data, rsp_ready=0, go to NCR.
  - NCR:
    - 0xFF keeps streaming; NCR_BYTES full 0xFF bytes must be sent, counted from the end of byte5.
    - If the user is late, extra 0xFF bytes are sent.
    - The R1 byte is loaded at the first boundary at which both conditions hold (response held and NCR count met) -> RESP.
  - RESP: after the 8 bits of R1 have been shifted -> IDLE (TX=0xFF).
- Back-to-back commands: a command start byte received while in WAIT_*/NCR/RESP is ignored; the host must wait for R1.
- Simultaneous CS rise and handshake completion: the abort wins, and the handshake is not counted.
- rst_n assertion mid-transfer: immediate return to reset values; no partial byte survives.

Optional Feature:
- SPI_SD_RESPONDER_CRC7_EN defined:
  - CRC7 (polynomial x^7+x^3+1, init 0) is computed over bytes 0..4 as they arrive and compared with byte5[7:1].
  - On mismatch: no cmd_valid. The block goes straight to NCR with internal response 0x09 (idle + CRC error) and skips the user handshake.
- Undefined: CRC is ignored, cmd_crc is passed through, and no CRC logic is synthesized.

Decomposition:
- Shared package spi_sd_pkg holds:
  - state enum (IDLE, CMD, WAIT_CMD, WAIT_RSP, NCR, RESP);
  - constants R1_IDLE=8'h01, R1_CRC_ERR=8'h08, FILL_BYTE=8'hFF, CMD_LEN=6.
- One sub-module, spi_sd_crc7: serial-in CRC7 with clear/enable, shared with the future host-side CRC generator.

Test Plan:
- CMD0 bytes 40 00 00 00 00 95, user responds 0x01 immediately -> cmd_index=0, cmd_arg=0x00000000, cmd_crc=0x4A; MISO shows FF (NCR_BYTES=1) then 01.
- Leading FF FF, then CMD8 48 00 00 01 AA 87 -> exactly one cmd_valid, index=8, arg=0x000001AA, crc=0x43; leading bytes ignored.
- cmd_ready held low for 40 SCLK cycles, then rsp 0x05 -> cmd_* stable throughout; MISO streams FF until the first boundary after rsp accept, then 05.
- CS_N raised after byte 3 of a command -> no cmd_valid, miso_oe=0. A fresh CMD0 afterward decodes correctly.
- rst_n pulsed low while R1 is shifting -> all outputs at reset values. The next command gets a normal response.
- With SPI_SD_RESPONDER_CRC7_EN: 40 00 00 00 00 01 -> no cmd_valid, MISO shows FF then 09. The same stimulus without the macro gives cmd_valid with cmd_crc=0x00.

Source files
------------

// File: rtl/spi_sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sd_pkg                                                           |
// | Shared types and constants for the SD-over-SPI card-side responder.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_sd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    WAIT_CMD = 3'd2,
    WAIT_RSP = 3'd3,
    NCR      = 3'd4,
    RESP     = 3'd5
  } state_t;

  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_CRC_ERR = 8'h08;
  localparam logic [7:0] FILL_BYTE  = 8'hFF;
  localparam int         CMD_LEN    = 6;

endpackage
`default_nettype wire

// File: rtl/spi_sd_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sd_responder_if                                                  |
// | SPI pins plus command/response handshake of the SD responder.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface spi_sd_responder_if;
  logic        sd_clk;
  logic        sd_mosi;
  logic        sd_cs_n;
  logic        sd_miso;
  logic        sd_miso_oe;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ready;

  // Host side: drives SPI pins and the user handshake inputs
  modport master (
    output sd_clk, sd_mosi, sd_cs_n, cmd_ready, rsp_valid, rsp_data,
    input  sd_miso, sd_miso_oe, cmd_valid, cmd_index, cmd_arg, cmd_crc, rsp_ready
  );

  modport slave (
    input  sd_clk, sd_mosi, sd_cs_n, cmd_ready, rsp_valid, rsp_data,
    output sd_miso, sd_miso_oe, cmd_valid, cmd_index, cmd_arg, cmd_crc, rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/spi_sd_crc7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sd_crc7                                                          |
// | Serial-in CRC7 (x^7 + x^3 + 1, init 0) with clear and enable.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_sd_crc7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb  = i_bit ^ r_crc[6];
  assign o_crc = r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[5:0], w_fb} ^ {3'b000, w_fb, 3'b000};
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_sd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sd_responder                                                     |
// | SPI mode-0 SD card-side responder: frames 6-byte commands, hands     |
// | them to user logic, returns R1 after NCR filler bytes.               |
// | Optional: SPI_SD_RESPONDER_CRC7_EN checks the command CRC7.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_sd_responder
  import spi_sd_pkg::*;
#(
  parameter int NCR_BYTES   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_sd_responder_if.slave  bus
);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_csn_sync;
  logic                   r_sclk_d, r_csn_d;
  logic                   w_sclk, w_mosi, w_csn;
  logic                   w_rise, w_fall, w_cs_fall, w_byte_done;

  state_t      r_state, w_state_next;
  logic [2:0]  r_cnt;
  logic [6:0]  r_rx;
  logic [7:0]  r_tx;
  logic [2:0]  r_byte_idx;
  logic [3:0]  r_ncr_cnt;
  logic        r_rsp_have;
  logic [7:0]  r_rsp_data;
  logic [5:0]  r_cmd_index;
  logic [31:0] r_cmd_arg;
  logic [6:0]  r_cmd_crc;

  logic [7:0]  w_rx_byte, w_tx_load;
  logic        w_start, w_last_cmd_byte, w_ncr_met, w_crc_bad;
  logic        w_cmd_valid, w_rsp_ready, w_cmd_fire, w_rsp_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '1;
      r_csn_sync  <= '1;
      r_sclk_d    <= 1'b0;
      r_csn_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sd_clk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.sd_mosi};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], bus.sd_cs_n};
      r_sclk_d    <= w_sclk;
      r_csn_d     <= w_csn;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_csn       = r_csn_sync[SYNC_STAGES-1];
  assign w_rise      = w_sclk & ~r_sclk_d & ~w_csn;
  assign w_fall      = ~w_sclk & r_sclk_d & ~w_csn;
  assign w_cs_fall   = r_csn_d & ~w_csn;
  assign w_byte_done = w_rise && (r_cnt == 3'd7);

  assign w_rx_byte       = {r_rx, w_mosi};
  assign w_start         = (w_rx_byte[7:6] == 2'b01);
  assign w_last_cmd_byte = (r_byte_idx == 3'(CMD_LEN - 1));
  // The byte finishing at this boundary counts toward the NCR fill
  assign w_ncr_met       = (r_ncr_cnt >= 4'(NCR_BYTES - 1));

`ifdef SPI_SD_RESPONDER_CRC7_EN
  logic       w_crc_clr, w_crc_en;
  logic [6:0] w_crc;

  // Bits of byte 0 are accumulated speculatively while IDLE; a non-start byte clears them
  assign w_crc_en  = w_rise && ((r_state == IDLE) || ((r_state == CMD) && !w_last_cmd_byte));
  assign w_crc_clr = w_csn || (w_byte_done && (r_state != CMD) && !((r_state == IDLE) && w_start));
  assign w_crc_bad = (w_rx_byte[7:1] != w_crc);

  spi_sd_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_bit (w_mosi),
    .o_crc (w_crc)
  );
`else
  assign w_crc_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; CS high aborts from anywhere
  always_comb begin
    w_state_next = r_state;
    if (w_csn) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (w_byte_done && w_start) w_state_next = CMD;
        CMD:      if (w_byte_done && w_last_cmd_byte) w_state_next = w_crc_bad ? NCR : WAIT_CMD;
        WAIT_CMD: if (w_cmd_fire) w_state_next = WAIT_RSP;
        WAIT_RSP: if (w_rsp_fire) w_state_next = NCR;
        NCR:      if (w_byte_done && r_rsp_have && w_ncr_met) w_state_next = RESP;
        RESP:     if (w_byte_done) w_state_next = IDLE;
        default:  w_state_next = IDLE;
      endcase
    end
  end

  // Outputs; handshakes are masked during CS high so an abort never completes one
  always_comb begin
    w_cmd_valid = (r_state == WAIT_CMD) && !w_csn;
    w_rsp_ready = (r_state == WAIT_RSP) && !w_csn;
    w_tx_load   = FILL_BYTE;
    if ((r_state == NCR) && r_rsp_have && w_ncr_met) w_tx_load = r_rsp_data;
  end

  assign w_cmd_fire = w_cmd_valid && bus.cmd_ready;
  assign w_rsp_fire = w_rsp_ready && bus.rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= FILL_BYTE;
      r_byte_idx  <= '0;
      r_ncr_cnt   <= '0;
      r_rsp_have  <= 1'b0;
      r_rsp_data  <= '0;
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_cmd_crc   <= '0;
    end else if (w_csn) begin
      r_cnt      <= '0;
      r_tx       <= FILL_BYTE;
      r_rsp_have <= 1'b0;
    end else begin
      if (w_cs_fall) begin
        r_cnt <= '0;
        r_tx  <= FILL_BYTE;
      end else if (w_rise) begin
        r_cnt <= r_cnt + 3'd1;
        r_rx  <= w_rx_byte[6:0];
        if (w_byte_done) r_tx <= w_tx_load;
      end else if (w_fall && (r_cnt != 3'd0)) begin
        // Skipped right after a boundary so the freshly loaded MSB stays on MISO
        r_tx <= {r_tx[6:0], 1'b1};
      end

      if (w_byte_done) begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_cmd_index <= w_rx_byte[5:0];
              r_byte_idx  <= 3'd1;
            end
          end
          CMD: begin
            if (!w_last_cmd_byte) begin
              r_cmd_arg  <= {r_cmd_arg[23:0], w_rx_byte};
              r_byte_idx <= r_byte_idx + 3'd1;
            end else begin
              r_cmd_crc <= w_rx_byte[7:1];
              r_ncr_cnt <= '0;
              if (w_crc_bad) begin
                r_rsp_have <= 1'b1;
                r_rsp_data <= R1_IDLE | R1_CRC_ERR;
              end
            end
          end
          WAIT_CMD, WAIT_RSP, NCR: begin
            if (r_ncr_cnt != 4'hF) r_ncr_cnt <= r_ncr_cnt + 4'd1;
          end
          default: ;
        endcase
      end

      if (w_rsp_fire) begin
        r_rsp_have <= 1'b1;
        r_rsp_data <= bus.rsp_data;
      end
      if ((r_state == NCR) && (w_state_next == RESP)) r_rsp_have <= 1'b0;
    end
  end

  assign bus.sd_miso_oe = ~w_csn;
  assign bus.sd_miso    = w_csn ? 1'b1 : r_tx[7];
  assign bus.cmd_valid  = w_cmd_valid;
  assign bus.rsp_ready  = w_rsp_ready;
  assign bus.cmd_index  = r_cmd_index;
  assign bus.cmd_arg    = r_cmd_arg;
  assign bus.cmd_crc    = r_cmd_crc;

endmodule
`default_nettype wire
